// File: rtl/fpmul_result_stage_if.sv
// Handshake bundle for the multiply result stage: packed-result inputs and the valid/ready FIFO output.
// The master modport is the upstream/consumer side; the slave modport is the result stage itself.
interface fpmul_result_stage_if;
   logic        in_valid;
   logic        in_sign;
   logic [6:0]  in_exp;
   logic [15:0] in_mantissa;
   logic        in_underflow;
   logic        in_overflow;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_data;
   logic [1:0]  out_exc;

   modport master (
      output in_valid, in_sign, in_exp, in_mantissa, in_underflow, in_overflow, out_ready,
      input  out_valid, out_data, out_exc
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mantissa, in_underflow, in_overflow, out_ready,
      output out_valid, out_data, out_exc
   );
endinterface

// File: rtl/fpmul_result_stage.sv
// Final float-multiply stage: exception packing into a first-word-fall-through result FIFO.
// Define FPMUL_STATS_EN to add the saturating sat_count/flush_count exception counters.
module fpmul_result_stage #(
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    fpmul_result_stage_if.slave      bus,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     err_drop
`ifdef FPMUL_STATS_EN
   ,output logic [CNT_W-1:0]         sat_count,
    output logic [CNT_W-1:0]         flush_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AF_LVL   = (PTR_W+1)'(DEPTH - AF_MARGIN);

    logic [23:0]      mem_data [DEPTH];
    logic [1:0]       mem_exc  [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   level;
    logic [23:0]      pack_data;
    logic [1:0]       pack_exc;
    logic             full, empty, pop, push_ok;

    // Overflow wins when both flags are set; exc still reports both.
    always_comb begin
        pack_data = {bus.in_sign, bus.in_exp, bus.in_mantissa};
        pack_exc  = {bus.in_overflow, bus.in_underflow};
        if (bus.in_overflow)
            pack_data = {bus.in_sign, 7'h7F, 16'hFFFF};
        else if (bus.in_underflow)
            pack_data = {bus.in_sign, 7'h00, 16'h0000};
    end

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign pop     = bus.out_valid & bus.out_ready;
    assign push_ok = bus.in_valid & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= pack_data;
            mem_exc[wr_ptr]  <= pack_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            err_drop    <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                level <= level + 1'b1;
            else if (pop && !push_ok)
                level <= level - 1'b1;
            if (bus.in_valid && full && !pop)
                err_drop <= 1'b1;
            // Registered from the registered level, so it trails level by one cycle.
            almost_full <= (level >= AF_LVL);
        end
    end

    assign fifo_level    = level;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? 24'h0 : mem_data[rd_ptr];
    assign bus.out_exc   = empty ? 2'b00 : mem_exc[rd_ptr];

`ifdef FPMUL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count   <= '0;
            flush_count <= '0;
        end else if (push_ok) begin
            if (pack_exc[1] && (sat_count != '1))
                sat_count <= sat_count + 1'b1;
            if ((pack_exc == 2'b01) && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fpmul_result_stage.sv
// Directed bench for fpmul_result_stage: packing cases, FIFO fill/drop/drain, full push+pop, reset mid-drain.
module tb_fpmul_result_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic       almost_full;
    logic [2:0] fifo_level;
    logic       err_drop;
    int         total = 0;
    int         bad   = 0;
`ifdef FPMUL_STATS_EN
    logic [15:0] sat_count, flush_count;
`endif

    fpmul_result_stage_if bus ();

    fpmul_result_stage #(.DEPTH(4), .AF_MARGIN(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .almost_full (almost_full),
        .fifo_level  (fifo_level),
        .err_drop    (err_drop)
`ifdef FPMUL_STATS_EN
       ,.sat_count   (sat_count),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [6:0] e,
                         input logic [15:0] m, input logic unf, input logic ovf);
        bus.in_valid     = v;
        bus.in_sign      = s;
        bus.in_exp       = e;
        bus.in_mantissa  = m;
        bus.in_underflow = unf;
        bus.in_overflow  = ovf;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Distinct normal words used for the fill/drain tests: {0, exp=k+1, mant=k*0x1111+0x0101}.
    function automatic logic [23:0] word(input int k);
        logic [6:0]  e;
        logic [15:0] m;
        e = 7'(k + 1);
        m = 16'(k * 16'h1111 + 16'h0101);
        return {1'b0, e, m};
    endfunction

    task automatic push_word(input int k);
        logic [23:0] w;
        w = word(k);
        drive(1'b1, w[23], w[22:16], w[15:0], 1'b0, 1'b0);
    endtask

    initial begin
        idle();
        bus.out_ready = 1'b0;
        do_reset();

        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_out_exc",   32'(bus.out_exc),   32'h0);
        check("rst_level",     32'(fifo_level),    32'h0);
        check("rst_af",        32'(almost_full),   32'h0);
        check("rst_err_drop",  32'(err_drop),      32'h0);

        // Normal product, FWFT latency of one cycle
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 7'd63, 16'h8000, 1'b0, 1'b0);
        tick();
        idle();
        check("norm_valid", 32'(bus.out_valid), 32'h1);
        check("norm_data",  32'(bus.out_data),  32'h3F8000);
        check("norm_exc",   32'(bus.out_exc),   32'h0);
        check("norm_level", 32'(fifo_level),    32'h1);
        tick();
        check("norm_drained", 32'(bus.out_valid), 32'h0);

        // Overflow saturates
        drive(1'b1, 1'b1, 7'd5, 16'h0000, 1'b0, 1'b1);
        tick();
        idle();
        check("ovf_data", 32'(bus.out_data), 32'hFFFFFF);
        check("ovf_exc",  32'(bus.out_exc),  32'h2);
        tick();

        // Underflow flushes to signed zero
        drive(1'b1, 1'b1, 7'h40, 16'h1234, 1'b1, 1'b0);
        tick();
        idle();
        check("unf_data", 32'(bus.out_data), 32'h800000);
        check("unf_exc",  32'(bus.out_exc),  32'h1);
        tick();

        // Both flags: saturate, exc reports both
        drive(1'b1, 1'b0, 7'h10, 16'h5555, 1'b1, 1'b1);
        tick();
        idle();
        check("both_data", 32'(bus.out_data), 32'h7FFFFF);
        check("both_exc",  32'(bus.out_exc),  32'h3);
        tick();

        // Negative normal pass-through
        drive(1'b1, 1'b1, 7'h12, 16'hABCD, 1'b0, 1'b0);
        tick();
        idle();
        check("neg_data", 32'(bus.out_data), 32'h92ABCD);
        check("neg_exc",  32'(bus.out_exc),  32'h0);
        tick();
`ifdef FPMUL_STATS_EN
        check("sat_count",   32'(sat_count),   32'd2);
        check("flush_count", 32'(flush_count), 32'd1);
`endif

        // Backpressure: fill, drop the 5th, drain in order
        bus.out_ready = 1'b0;
        push_word(0); tick();
        check("bp_lvl1", 32'(fifo_level),  32'd1);
        check("bp_af1",  32'(almost_full), 32'h0);
        push_word(1); tick();
        check("bp_lvl2", 32'(fifo_level),  32'd2);
        check("bp_af2_lag", 32'(almost_full), 32'h0);
        push_word(2); tick();
        check("bp_lvl3", 32'(fifo_level),  32'd3);
        check("bp_af3",  32'(almost_full), 32'h1);
        push_word(3); tick();
        check("bp_lvl4", 32'(fifo_level),  32'd4);
        check("bp_err0", 32'(err_drop),    32'h0);
        push_word(4); tick();
        idle();
        check("bp_drop_lvl",  32'(fifo_level),   32'd4);
        check("bp_drop_err",  32'(err_drop),     32'h1);
        check("bp_hold_head", 32'(bus.out_data), 32'(word(0)));
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_drain_valid", 32'(bus.out_valid), 32'h1);
            check("bp_drain_data",  32'(bus.out_data),  32'(word(k)));
            tick();
        end
        check("bp_empty_valid", 32'(bus.out_valid), 32'h0);
        check("bp_empty_level", 32'(fifo_level),    32'd0);
        check("bp_err_sticky",  32'(err_drop),      32'h1);

        // Full with simultaneous push+pop
        do_reset();
        check("rst2_err", 32'(err_drop), 32'h0);
        bus.out_ready = 1'b0;
        for (int k = 10; k < 14; k++) begin
            push_word(k);
            tick();
        end
        check("pp_full", 32'(fifo_level), 32'd4);
        bus.out_ready = 1'b1;
        push_word(14);
        tick();
        idle();
        check("pp_level", 32'(fifo_level), 32'd4);
        check("pp_err",   32'(err_drop),   32'h0);
        for (int k = 11; k < 15; k++) begin
            check("pp_drain_data", 32'(bus.out_data), 32'(word(k)));
            tick();
        end
        check("pp_empty", 32'(bus.out_valid), 32'h0);

        // Reset mid-drain at level 3, after a drop and some exceptions
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b0, 7'h01, 16'h0001, 1'b0, 1'b1); tick();
        drive(1'b1, 1'b0, 7'h01, 16'h0001, 1'b1, 1'b0); tick();
        push_word(20); tick();
        push_word(21); tick();
        push_word(22); tick();
        check("md_err_set", 32'(err_drop), 32'h1);
        idle();
        bus.out_ready = 1'b1;
        tick();
        check("md_level3", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        tick();
        check("md_valid",  32'(bus.out_valid), 32'h0);
        check("md_level",  32'(fifo_level),    32'd0);
        check("md_err",    32'(err_drop),      32'h0);
        check("md_data",   32'(bus.out_data),  32'h0);
`ifdef FPMUL_STATS_EN
        check("md_sat",    32'(sat_count),     32'd0);
        check("md_flush",  32'(flush_count),   32'd0);
`endif
        tick();
        check("md_af", 32'(almost_full), 32'h0);
        rst = 1'b0;
        tick();
        check("md_post_valid", 32'(bus.out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
